// File: rtl/sd_multipiece_mod.sv
// Multi-level (NPIECE-element) sigma-delta modulator, 1st or 2nd order, with
// optional data-weighted-averaging element rotation and a frame-aligned
// valid/ready input handshake.
module sd_multipiece_mod #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned NPIECE   = 4,
  parameter int unsigned ORDER    = 1,
  parameter int unsigned ACCW     = BITWIDTH + 4,
  parameter int unsigned FRAME    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BITWIDTH-1:0]     kin,
  input  logic                    kin_valid,
  output logic                    kin_ready,
  input  logic                    dwa_en,
  output logic [NPIECE-1:0]       sd_out,
  output logic [$clog2(NPIECE):0] level,
  output logic                    ovf
);

  localparam int unsigned PW = $clog2(NPIECE);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned FW = $clog2(FRAME);
  localparam int unsigned SH = BITWIDTH - PW;  // log2(STEP), STEP = 2H/NPIECE
  localparam int unsigned SW = ACCW + 2;       // working width: no wrap before sat()

  localparam logic signed [SW-1:0] ACC_MAX = {3'b000, {(ACCW-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = {3'b111, {(ACCW-1){1'b0}}};
  localparam logic signed [SW-1:0] Q_BIAS  = (SW'(1) << (BITWIDTH-1)) + (SW'(1) << (SH-1));
  localparam logic signed [SW-1:0] HALF_N  = SW'(NPIECE / 2);
  localparam logic signed [SW-1:0] FULL_N  = SW'(NPIECE);
  localparam logic [LW-1:0]        LVL_RST = LW'(NPIECE / 2);
  localparam logic [NPIECE-1:0]    SD_RST  = NPIECE'((64'd1 << (NPIECE / 2)) - 64'd1);

  // Illegal parameterisations stop elaboration.
  if (ORDER != 1 && ORDER != 2) begin : g_bad_order
    $error("sd_multipiece_mod: ORDER must be 1 or 2");
  end
  if (NPIECE < 2 || NPIECE > 16 || (NPIECE & (NPIECE - 1)) != 0) begin : g_bad_npiece
    $error("sd_multipiece_mod: NPIECE must be 2, 4, 8 or 16");
  end
  if (FRAME < 2 || (FRAME & (FRAME - 1)) != 0) begin : g_bad_frame
    $error("sd_multipiece_mod: FRAME must be a power of 2, at least 2");
  end

  logic signed [BITWIDTH-1:0] x_q, x_d;
  logic signed [ACCW-1:0]     acc1_q, acc1_d;
  logic signed [ACCW-1:0]     acc2_q, acc2_d;
  logic [FW-1:0]              frame_q, frame_d;
  logic [PW-1:0]              ptr_q, ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic [NPIECE-1:0]          sd_q, sd_d;
  logic                       ovf_q, ovf_d;

  logic signed [SW-1:0]   x_ext, fb, a1, a2, q_sum, k_raw;
  logic signed [ACCW-1:0] s1, s2, q_in;
  logic                   clip1, clip2;
  logic [NPIECE-1:0]      therm, rot;
  logic [PW-1:0]          idx;

  function automatic logic signed [SW-1:0] sext_acc(input logic signed [ACCW-1:0] v);
    return {{(SW-ACCW){v[ACCW-1]}}, v};
  endfunction

  function automatic logic clips(input logic signed [SW-1:0] v);
    return (v > ACC_MAX) || (v < ACC_MIN);
  endfunction

  function automatic logic signed [ACCW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > ACC_MAX) return ACC_MAX[ACCW-1:0];
    if (v < ACC_MIN) return ACC_MIN[ACCW-1:0];
    return v[ACCW-1:0];
  endfunction

  // Input is only taken on the first cycle of each frame, never during reset.
  assign kin_ready = (frame_q == '0) && reset;

  // Loop filter, quantiser and element mapping for the coming edge.
  always_comb begin
    x_d     = x_q;
    frame_d = frame_q + FW'(1);
    ptr_d   = ptr_q;
    idx     = '0;
    therm   = '0;
    rot     = '0;

    if (kin_valid && kin_ready) begin
      x_d = kin;
    end

    x_ext = {{(SW-BITWIDTH){x_q[BITWIDTH-1]}}, x_q};
    // (level - NPIECE/2) * STEP is the DAC value of the previous output.
    fb    = ($signed({{(SW-LW){1'b0}}, level_q}) - HALF_N) <<< SH;

    a1    = sext_acc(acc1_q) + x_ext - fb;
    s1    = sat(a1);
    clip1 = clips(a1);
    a2    = sext_acc(acc2_q) + sext_acc(s1) - fb;
    s2    = sat(a2);
    clip2 = clips(a2) && (ORDER == 2);

    acc1_d = s1;
    acc2_d = (ORDER == 2) ? s2 : '0;
    q_in   = (ORDER == 2) ? s2 : s1;
    ovf_d  = ovf_q || clip1 || clip2;

    // Round to nearest level: floor((q + H + STEP/2) / STEP), clamped.
    q_sum = sext_acc(q_in) + Q_BIAS;
    k_raw = q_sum >>> SH;
    if (k_raw[SW-1]) begin
      level_d = '0;
    end else if (k_raw > FULL_N) begin
      level_d = LW'(NPIECE);
    end else begin
      level_d = k_raw[LW-1:0];
    end

    for (int unsigned i = 0; i < NPIECE; i++) begin
      therm[i] = (LW'(i) < level_d);
    end
    // Rotated thermometer: bit i is on when (i - ptr) mod NPIECE < level.
    for (int unsigned i = 0; i < NPIECE; i++) begin
      idx    = PW'(i) - ptr_q;
      rot[i] = therm[idx];
    end

    if (dwa_en) begin
      sd_d  = rot;
      ptr_d = ptr_q + PW'(level_d);
    end else begin
      sd_d  = therm;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q     <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      frame_q <= '0;
      ptr_q   <= '0;
      level_q <= LVL_RST;
      sd_q    <= SD_RST;
      ovf_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      frame_q <= frame_d;
      ptr_q   <= ptr_d;
      level_q <= level_d;
      sd_q    <= sd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sd_out = sd_q;
  assign level  = level_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_sd_multipiece_mod.sv
// Bench for sd_multipiece_mod: two instances (ORDER 1 and ORDER 2) share the
// same stimulus; a reference model pushes expected outputs per edge and a
// monitor pops and compares on the falling edge.
module tb_sd_multipiece_mod;

  localparam longint H    = 32768;
  localparam longint STEP = 16384;
  localparam longint AMAX = 524287;
  localparam longint AMIN = -524288;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] kin;
  logic        kin_valid;
  logic        dwa_en;
  logic        rdy0, rdy1, ovf0, ovf1;
  logic [3:0]  sd0, sd1;
  logic [2:0]  lvl0, lvl1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    longint x, acc1, acc2;
    int     frame, ptr, lvl, sd;
    bit     ovf;
  } mdl_t;

  typedef struct {
    int lvl;
    int sd;
    bit ovf;
    bit frame0;
  } exp_t;

  mdl_t m [2];
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;

  sd_multipiece_mod #(.BITWIDTH(16), .NPIECE(4), .ORDER(1), .FRAME(8)) u_o1 (
    .clk(clk), .reset(reset), .kin(kin), .kin_valid(kin_valid), .kin_ready(rdy0),
    .dwa_en(dwa_en), .sd_out(sd0), .level(lvl0), .ovf(ovf0)
  );

  sd_multipiece_mod #(.BITWIDTH(16), .NPIECE(4), .ORDER(2), .FRAME(8)) u_o2 (
    .clk(clk), .reset(reset), .kin(kin), .kin_valid(kin_valid), .kin_ready(rdy1),
    .dwa_en(dwa_en), .sd_out(sd1), .level(lvl1), .ovf(ovf1)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  function automatic longint clampa(input longint v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  // Reference model: one update per rising edge, d=0 is ORDER 1, d=1 is ORDER 2.
  task automatic model_step();
    exp_t   e;
    longint fb, a1, a2, s1, s2, q, v, k;
    bit     rdy;
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        m[d].x = 0; m[d].acc1 = 0; m[d].acc2 = 0;
        m[d].frame = 0; m[d].ptr = 0; m[d].lvl = 2; m[d].sd = 3; m[d].ovf = 1'b0;
      end else begin
        rdy = (m[d].frame == 0);
        fb  = longint'(m[d].lvl - 2) * STEP;
        a1  = m[d].acc1 + m[d].x - fb;
        s1  = clampa(a1);
        if (s1 != a1) m[d].ovf = 1'b1;
        q = s1;
        if (d == 1) begin
          a2 = m[d].acc2 + s1 - fb;
          s2 = clampa(a2);
          if (s2 != a2) m[d].ovf = 1'b1;
          m[d].acc2 = s2;
          q = s2;
        end
        m[d].acc1 = s1;
        v = q + H + STEP / 2;
        k = v / STEP;
        if ((v % STEP != 0) && (v < 0)) k = k - 1;
        if (k < 0) k = 0;
        if (k > 4) k = 4;
        m[d].lvl = int'(k);
        m[d].sd  = 0;
        for (int j = 0; j < m[d].lvl; j++) begin
          m[d].sd = m[d].sd | (1 << (dwa_en ? (m[d].ptr + j) % 4 : j));
        end
        if (dwa_en) m[d].ptr = (m[d].ptr + m[d].lvl) % 4;
        if (kin_valid && rdy) begin
          m[d].x = longint'(kin);
          if (kin[15]) m[d].x = m[d].x - 65536;
        end
        m[d].frame = (m[d].frame + 1) % 8;
      end
      e.lvl = m[d].lvl; e.sd = m[d].sd; e.ovf = m[d].ovf; e.frame0 = (m[d].frame == 0);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: one expected entry per edge per instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("o1_level", longint'(lvl0), e.lvl);
        chk("o1_sd_out", longint'(sd0), e.sd);
        chk("o1_ovf", longint'(ovf0), longint'(e.ovf));
        chk("o1_kin_ready", longint'(rdy0), longint'(e.frame0 && reset));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("o2_level", longint'(lvl1), e.lvl);
        chk("o2_sd_out", longint'(sd1), e.sd);
        chk("o2_ovf", longint'(ovf1), longint'(e.ovf));
        chk("o2_kin_ready", longint'(rdy1), longint'(e.frame0 && reset));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    bit took;
    took      = 1'b0;
    kin       = v;
    kin_valid = 1'b1;
    for (int n = 0; n < 20 && !took; n++) begin
      took = rdy0;
      step();
    end
    kin_valid = 1'b0;
    chk("send_accepted", longint'(took), 1);
  endtask

  initial begin
    int     n;
    longint sum;
    int     cnt [4];
    int     seq [5];
    seq = '{1, 2, 4, 8, 1};

    reset = 1'b0; kin = '0; kin_valid = 1'b0; dwa_en = 1'b0;
    repeat (3) step();
    chk("rst_level_o1", longint'(lvl0), 2);
    chk("rst_sd_o1", longint'(sd0), 3);
    chk("rst_ovf_o2", longint'(ovf1), 0);
    chk("rst_ready_low", longint'(rdy0), 0);
    reset = 1'b1;

    // Zero input: mid-level, fixed pattern.
    send(16'h0000);
    repeat (16) begin
      step();
      chk("t1_level", longint'(lvl0), 2);
      chk("t1_sd", longint'(sd0), 3);
      chk("t1_ovf", longint'(ovf0), 0);
    end

    // +H/2 then -H/2.
    send(16'h4000);
    repeat (10) step();
    repeat (4) begin step(); chk("t2_level_hi", longint'(lvl0), 3); end
    send(16'hC000);
    repeat (10) step();
    repeat (4) begin step(); chk("t2_level_lo", longint'(lvl0), 1); end

    // DWA rotation of a single active element.
    dwa_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_dwa_sd", longint'(sd0), seq[i]);
    end
    cnt = '{0, 0, 0, 0};
    repeat (8) begin
      step();
      for (int b = 0; b < 4; b++) cnt[b] += int'(sd0[b]);
    end
    for (int b = 0; b < 4; b++) chk("t3_element_use", cnt[b], 2);

    // Handshake raised mid-frame waits for the frame boundary.
    n = 0;
    while (!rdy0 && n < 20) begin step(); n++; end
    chk("t4_sync", longint'(rdy0), 1);
    repeat (3) step();
    kin = 16'h4000; kin_valid = 1'b1;
    n = 0;
    while (!rdy0 && n < 20) begin
      chk("t4_level_hold", longint'(lvl0), 1);
      step();
      n++;
    end
    chk("t4_ready_low_cycles", n, 5);
    step();
    kin_valid = 1'b0;
    chk("t4_level_after_accept", longint'(lvl0), 1);
    step();
    chk("t4_level_two_edges", longint'(lvl0), 3);

    // Near full scale into the 2nd-order loop.
    dwa_en = 1'b0;
    send(16'h7FFF);
    sum = 0;
    repeat (1000) begin
      step();
      chk_range("t5_level_bounds", longint'(lvl1), 0, 4);
      sum += longint'(lvl1);
    end
    chk_range("t5_mean_level_x1000", sum, 3900, 4000);

    // Randomised traffic with occasional resets.
    repeat (1500) begin
      kin       = 16'($urandom);
      kin_valid = 1'($urandom_range(0, 1));
      dwa_en    = ($urandom_range(0, 2) == 0);
      reset     = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1; kin_valid = 1'b0;
    repeat (4) step();

    // One-cycle reset with a pending sample.
    dwa_en = 1'b0; kin = 16'h3000; kin_valid = 1'b1; reset = 1'b0;
    step();
    chk("t6_level_o1", longint'(lvl0), 2);
    chk("t6_level_o2", longint'(lvl1), 2);
    chk("t6_sd_o1", longint'(sd0), 3);
    chk("t6_sd_o2", longint'(sd1), 3);
    chk("t6_ovf_o2", longint'(ovf1), 0);
    chk("t6_ready_in_reset", longint'(rdy0), 0);
    reset = 1'b1; kin_valid = 1'b0;
    repeat (12) begin
      step();
      chk("t6_no_capture_o1", longint'(lvl0), 2);
      chk("t6_no_capture_o2", longint'(lvl1), 2);
    end

    @(negedge clk);
    #1;
    chk("sb_drain", longint'(q0.size() + q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
